// File: rtl/rv32i_cpu_subsystem_if.sv
// External memory-mapped data bus of the RV32I subsystem.
// Carries every data access that falls outside the local RAM window out to
// the system peripherals (LED, seg, keyboard, timer, VGA, serial).
//   addr  : data address, valid every cycle
//   wdata : store data, byte/half replicated across lanes
//   rdata : read data returned by the peripheral, used in the same cycle
//   op    : access size/sign (funct3 of the load/store)
//   we/re : store/load strobe to external space, held for the whole cycle
interface rv32i_cpu_subsystem_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  op;
    logic        we;
    logic        re;

    modport master (output addr, wdata, op, we, re, input rdata);
    modport slave  (input addr, wdata, op, we, re, output rdata);
endinterface

// File: rtl/rv32i_cpu_subsystem.sv
// Single-cycle RV32I core with word-organised instruction ROM and
// byte-addressable data RAM. One instruction retires per rising clock edge.
// Ports:
//   clock    : system clock, all state updates on the rising edge
//   reset    : asynchronous, active-high; PC and x1..x31 cleared
//   ext      : master side of the external data bus (accesses outside RAM)
//   dbg_pc   : PC of the instruction currently executing
//   dbg_data : current value of x10 (a0)
module rv32i_cpu_subsystem #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IMEM_AW   = 14,
    parameter string       IMEM_INIT = "",
    parameter int          DMEM_AW   = 14,
    parameter logic [31:0] DMEM_BASE = 32'h0010_0000
) (
    input  logic                          clock,
    input  logic                          reset,
    rv32i_cpu_subsystem_if.master         ext,
    output logic [31:0]                   dbg_pc,
    output logic [31:0]                   dbg_data
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    // Clears the offset bits inside the RAM window for the base compare.
    localparam logic [31:0] DMEM_MASK = ~((32'd4 << DMEM_AW) - 32'd1);

    logic [31:0] imem_rom [0:(1<<IMEM_AW)-1];
    logic [31:0] dmem_ram [0:(1<<DMEM_AW)-1];

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] x_q [0:31];
    logic        rd_we_d;
    logic [31:0] rd_wdata_d;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, alu_b, alu_res, mem_addr;
    logic        alu_alt, is_load, is_store, in_ram, br_taken;
    logic [DMEM_AW-1:0] ram_idx;
    logic [31:0] ld_word, ld_val, st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [3:0]  ram_be;
    logic        ram_we, ext_we_raw, ext_re_raw;

    // Fetch: upper PC bits are ignored, so the index wraps within the ROM.
    assign instr  = imem_rom[pc_q[IMEM_AW+1:2]];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'h000};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : x_q[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : x_q[rs2];
    assign pc_plus4 = pc_q + 32'd4;

    // instr[30] selects SUB only for register ADD, but SRA/SRAI for both forms.
    assign alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    assign alu_alt = instr[30] && ((f3 == 3'b101) || (f3 == 3'b000 && opcode == OPC_OP));

    always_comb begin
        alu_res = 32'd0;
        case (f3)
            3'b000:  alu_res = alu_alt ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_res = rs1_val << alu_b[4:0];
            3'b010:  alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_res = {31'd0, rs1_val < alu_b};
            3'b100:  alu_res = rs1_val ^ alu_b;
            3'b101:  alu_res = alu_alt ? $unsigned($signed(rs1_val) >>> alu_b[4:0])
                                       : rs1_val >> alu_b[4:0];
            3'b110:  alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (f3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val <  rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);
    assign mem_addr = rs1_val + (is_store ? imm_s : imm_i);
    assign in_ram   = ((mem_addr & DMEM_MASK) == DMEM_BASE);
    assign ram_idx  = mem_addr[DMEM_AW+1:2];
    assign ld_word  = in_ram ? dmem_ram[ram_idx] : ext.rdata;

    // Lane select: bytes by addr[1:0], halves by addr[1] only.
    always_comb begin
        ld_byte = ld_word[7:0];
        case (mem_addr[1:0])
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            2'd3:    ld_byte = ld_word[31:24];
            default: ld_byte = ld_word[7:0];
        endcase
        ld_half = mem_addr[1] ? ld_word[31:16] : ld_word[15:0];
        ld_val  = ld_word;
        st_data = rs2_val;
        ram_be  = 4'b1111;
        case (f3[1:0])
            2'b00: begin
                ld_val  = f3[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
                st_data = {4{rs2_val[7:0]}};
                ram_be  = 4'b0001 << mem_addr[1:0];
            end
            2'b01: begin
                ld_val  = f3[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
                st_data = {2{rs2_val[15:0]}};
                ram_be  = mem_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                ld_val  = ld_word;
                st_data = rs2_val;
                ram_be  = 4'b1111;
            end
        endcase
    end

    // Main decode. Unlisted opcodes (FENCE, SYSTEM, undefined) fall to the
    // defaults: PC+4 with no register, RAM or bus write.
    always_comb begin
        pc_d       = pc_plus4;
        rd_we_d    = 1'b0;
        rd_wdata_d = alu_res;
        ram_we     = 1'b0;
        ext_we_raw = 1'b0;
        ext_re_raw = 1'b0;
        case (opcode)
            OPC_LUI:   begin rd_we_d = 1'b1; rd_wdata_d = imm_u; end
            OPC_AUIPC: begin rd_we_d = 1'b1; rd_wdata_d = pc_q + imm_u; end
            OPC_JAL: begin
                rd_we_d    = 1'b1;
                rd_wdata_d = pc_plus4;
                pc_d       = pc_q + imm_j;
            end
            OPC_JALR: begin
                // Target is formed from the old rs1 even when rd == rs1.
                rd_we_d    = 1'b1;
                rd_wdata_d = pc_plus4;
                pc_d       = (rs1_val + imm_i) & ~32'd1;
            end
            OPC_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
            OPC_LOAD: begin
                rd_we_d    = 1'b1;
                rd_wdata_d = ld_val;
                ext_re_raw = !in_ram;
            end
            OPC_STORE: begin
                ram_we     = in_ram;
                ext_we_raw = !in_ram;
            end
            OPC_OPIMM, OPC_OP: rd_we_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) x_q[i] <= 32'd0;
        end else if (rd_we_d && rd != 5'd0) begin
            x_q[rd] <= rd_wdata_d;
        end
    end

    // RAM keeps its contents through reset; a store is dropped on an edge
    // where reset is high so a mid-instruction reset leaves memory intact.
    always_ff @(posedge clock) begin
        if (ram_we && !reset) begin
            for (int i = 0; i < 4; i++)
                if (ram_be[i]) dmem_ram[ram_idx][i*8 +: 8] <= st_data[i*8 +: 8];
        end
    end

    assign ext.addr  = (is_load || is_store) ? mem_addr : alu_res;
    assign ext.wdata = is_store ? st_data : rs2_val;
    assign ext.op    = f3;
    assign ext.we    = ext_we_raw && !reset;
    assign ext.re    = ext_re_raw && !reset;

    assign dbg_pc   = pc_q;
    assign dbg_data = x_q[10];
endmodule

// File: tb/tb_rv32i_cpu_subsystem.sv
module tb_rv32i_cpu_subsystem;
    logic        clock;
    logic        reset;
    logic [31:0] dbg_pc;
    logic [31:0] dbg_data;
    int          checks;
    int          errors;
    logic [31:0] prog [64];

    localparam logic [6:0] OPI = 7'h13, LD = 7'h03, LUI = 7'h37, AUIPC = 7'h17, JALR = 7'h67;

    rv32i_cpu_subsystem_if ext_if ();

    rv32i_cpu_subsystem dut (
        .clock    (clock),
        .reset    (reset),
        .ext      (ext_if),
        .dbg_pc   (dbg_pc),
        .dbg_data (dbg_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] enc_i(input logic [6:0] op, input int rd, input logic [2:0] f3,
                                          input int rs1, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[11:0], rs1[4:0], f3, rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input logic [2:0] f3, input int rs2, input int rs1, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[11:5], rs2[4:0], rs1[4:0], f3, v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input int rs1, input int rs2, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], rs2[4:0], rs1[4:0], f3, v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] op, input int rd, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[19:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_j(input int rd, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rd[4:0], 7'h6F};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    endtask

    // Hold reset, copy the program into the ROM, release on a falling edge.
    task automatic start_prog();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 64; i++) dut.imem_rom[i] = prog[i];
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] exp_a [1:18];
    logic [31:0] exp_b [1:19];
    logic [31:0] exp_d_pc [1:20];
    logic [31:0] exp_d_a0 [1:20];

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        ext_if.rdata = 32'd0;

        // ---------------- ALU / immediates ----------------
        clear_prog();
        prog[0]  = enc_i(OPI, 1, 3'd0, 0, -5);          // addi x1,x0,-5
        prog[1]  = enc_i(OPI, 2, 3'd5, 1, 'h401);       // srai x2,x1,1
        prog[2]  = enc_r(7'h00, 1, 0, 3'd3, 3);         // sltu x3,x0,x1
        prog[3]  = enc_u(LUI, 10, 'h12345);             // lui a0,0x12345
        prog[4]  = enc_i(OPI, 10, 3'd0, 10, 'h678);     // addi a0,a0,0x678
        prog[5]  = enc_i(OPI, 10, 3'd0, 2, 0);          // mv a0,x2
        prog[6]  = enc_i(OPI, 10, 3'd0, 3, 0);          // mv a0,x3
        prog[7]  = enc_r(7'h20, 1, 0, 3'd0, 10);        // sub a0,x0,x1
        prog[8]  = enc_r(7'h00, 0, 1, 3'd2, 10);        // slt a0,x1,x0
        prog[9]  = enc_r(7'h00, 1, 3, 3'd1, 10);        // sll a0,x3,x1 (shamt 27)
        prog[10] = enc_r(7'h00, 3, 1, 3'd5, 10);        // srl a0,x1,x3
        prog[11] = enc_i(OPI, 10, 3'd4, 1, -1);         // xori a0,x1,-1
        prog[12] = enc_u(AUIPC, 10, 1);                 // auipc a0,1 @0x30
        prog[13] = enc_r(7'h20, 3, 1, 3'd5, 10);        // sra a0,x1,x3
        prog[14] = enc_i(OPI, 10, 3'd2, 1, -4);         // slti a0,x1,-4
        prog[15] = enc_i(OPI, 10, 3'd7, 1, 'hF0);       // andi a0,x1,0xF0
        prog[16] = enc_i(OPI, 10, 3'd6, 0, -2048);      // ori a0,x0,-2048
        prog[17] = enc_r(7'h00, 1, 1, 3'd0, 10);        // add a0,x1,x1
        exp_a = '{32'h0, 32'h0, 32'h0, 32'h12345000, 32'h12345678, 32'hFFFFFFFD,
                  32'h1, 32'h5, 32'h1, 32'h08000000, 32'h7FFFFFFD, 32'h4, 32'h1030,
                  32'hFFFFFFFD, 32'h1, 32'hF0, 32'hFFFFF800, 32'hFFFFFFF6};
        start_prog();
        chk("reset pc", dbg_pc, 32'h0);
        chk("reset a0", dbg_data, 32'h0);
        chk("reset we", {31'd0, ext_if.we}, 32'h0);
        chk("reset re", {31'd0, ext_if.re}, 32'h0);
        for (int n = 1; n <= 18; n++) begin
            step();
            chk($sformatf("alu pc n=%0d", n), dbg_pc, 32'(4 * n));
            chk($sformatf("alu a0 n=%0d", n), dbg_data, exp_a[n]);
        end

        // ---------------- RAM byte/half/word ----------------
        clear_prog();
        prog[0]  = enc_u(LUI, 5, 'h100);                // x5 = 0x00100000
        prog[1]  = enc_u(LUI, 6, 'h8);
        prog[2]  = enc_i(OPI, 6, 3'd0, 6, 'hFF);        // x6 = 0x80FF
        prog[3]  = enc_s(3'd2, 6, 5, 0);                // sw x6,0(x5)
        prog[4]  = enc_i(LD, 7, 3'd0, 5, 0);            // lb x7
        prog[5]  = enc_i(LD, 8, 3'd4, 5, 0);            // lbu x8
        prog[6]  = enc_i(LD, 9, 3'd1, 5, 0);            // lh x9
        prog[7]  = enc_s(3'd0, 0, 5, 1);                // sb x0,1(x5)
        prog[8]  = enc_i(LD, 10, 3'd2, 5, 0);           // lw a0
        prog[9]  = enc_i(OPI, 10, 3'd0, 7, 0);
        prog[10] = enc_i(OPI, 10, 3'd0, 8, 0);
        prog[11] = enc_i(OPI, 10, 3'd0, 9, 0);
        prog[12] = enc_s(3'd1, 6, 5, 2);                // sh x6,2(x5)
        prog[13] = enc_i(LD, 10, 3'd5, 5, 2);           // lhu a0,2(x5)
        prog[14] = enc_i(LD, 10, 3'd0, 5, 3);           // lb a0,3(x5)
        prog[15] = enc_i(LD, 10, 3'd4, 5, 2);           // lbu a0,2(x5)
        prog[16] = enc_i(LD, 10, 3'd1, 5, 3);           // lh a0,3(x5)
        prog[17] = enc_s(3'd2, 6, 5, 4);                // sw x6,4(x5)
        prog[18] = enc_i(LD, 10, 3'd2, 5, 4);           // lw a0,4(x5)
        exp_b = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                  32'hFF, 32'hFFFFFFFF, 32'hFF, 32'hFFFF80FF, 32'hFFFF80FF, 32'h80FF,
                  32'hFFFFFF80, 32'hFF, 32'hFFFF80FF, 32'hFFFF80FF, 32'h80FF};
        start_prog();
        for (int n = 1; n <= 19; n++) begin
            step();
            chk($sformatf("ram a0 n=%0d", n), dbg_data, exp_b[n]);
            chk($sformatf("ram we n=%0d", n), {31'd0, ext_if.we}, 32'h0);
            chk($sformatf("ram re n=%0d", n), {31'd0, ext_if.re}, 32'h0);
        end

        // ---------------- External bus and window edges ----------------
        clear_prog();
        prog[0]  = enc_u(LUI, 5, 'h200);                // x5 = 0x00200000
        prog[1]  = enc_u(LUI, 6, 'hB);
        prog[2]  = enc_i(OPI, 6, 3'd0, 6, -1075);       // x6 = 0xABCD
        prog[3]  = enc_s(3'd1, 6, 5, 2);                // sh x6,2(x5)
        prog[4]  = enc_i(LD, 10, 3'd2, 5, 0);           // lw a0,0(x5)
        prog[5]  = enc_i(LD, 10, 3'd4, 5, 3);           // lbu a0,3(x5)
        prog[6]  = enc_i(LD, 10, 3'd1, 5, 2);           // lh a0,2(x5)
        prog[7]  = enc_u(LUI, 12, 'h110);               // x12 = 0x00110000
        prog[8]  = enc_s(3'd2, 6, 12, -4);              // sw x6,-4(x12): last RAM word
        prog[9]  = enc_s(3'd2, 6, 12, 0);               // sw x6,0(x12): first word past RAM
        prog[10] = enc_i(LD, 10, 3'd2, 12, -4);         // lw a0,-4(x12)
        prog[11] = enc_u(LUI, 13, 'h100);
        prog[12] = enc_i(LD, 10, 3'd2, 13, -4);         // lw a0,-4(x13): just below RAM
        ext_if.rdata = 32'hDEADBEEF;
        start_prog();
        for (int n = 1; n <= 3; n++) step();
        chk("sh we", {31'd0, ext_if.we}, 32'h1);
        chk("sh re", {31'd0, ext_if.re}, 32'h0);
        chk("sh addr", ext_if.addr, 32'h00200002);
        chk("sh op", {29'd0, ext_if.op}, 32'h1);
        chk("sh wdata", ext_if.wdata, 32'hABCDABCD);
        step();
        chk("lw re", {31'd0, ext_if.re}, 32'h1);
        chk("lw we", {31'd0, ext_if.we}, 32'h0);
        chk("lw addr", ext_if.addr, 32'h00200000);
        chk("lw op", {29'd0, ext_if.op}, 32'h2);
        step();
        chk("lw a0", dbg_data, 32'hDEADBEEF);
        chk("lbu re", {31'd0, ext_if.re}, 32'h1);
        chk("lbu addr", ext_if.addr, 32'h00200003);
        chk("lbu op", {29'd0, ext_if.op}, 32'h4);
        step();
        chk("lbu a0", dbg_data, 32'h000000DE);
        step();
        chk("lh a0", dbg_data, 32'hFFFFDEAD);
        chk("lui re", {31'd0, ext_if.re}, 32'h0);
        ext_if.rdata = 32'h12345678;
        step();
        chk("ram-top we", {31'd0, ext_if.we}, 32'h0);
        chk("ram-top addr", ext_if.addr, 32'h0010FFFC);
        step();
        chk("past-ram we", {31'd0, ext_if.we}, 32'h1);
        chk("past-ram addr", ext_if.addr, 32'h00110000);
        chk("past-ram wdata", ext_if.wdata, 32'h0000ABCD);
        chk("past-ram op", {29'd0, ext_if.op}, 32'h2);
        step();
        chk("ram-top lw re", {31'd0, ext_if.re}, 32'h0);
        step();
        chk("ram-top a0", dbg_data, 32'h0000ABCD);
        step();
        chk("below-ram re", {31'd0, ext_if.re}, 32'h1);
        chk("below-ram addr", ext_if.addr, 32'h000FFFFC);
        step();
        chk("below-ram a0", dbg_data, 32'h12345678);

        // ---------------- Async reset mid-instruction ----------------
        clear_prog();
        prog[0] = enc_u(LUI, 5, 'h200);
        prog[1] = enc_u(LUI, 10, 'h77);                 // a0 = 0x00077000
        prog[2] = enc_s(3'd2, 10, 5, 0);                // sw a0,0(x5) -> external
        start_prog();
        step();
        step();
        chk("pre-rst a0", dbg_data, 32'h00077000);
        chk("pre-rst we", {31'd0, ext_if.we}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst pc", dbg_pc, 32'h0);
        chk("rst a0", dbg_data, 32'h0);
        chk("rst we", {31'd0, ext_if.we}, 32'h0);
        step();
        chk("rst-held pc", dbg_pc, 32'h0);
        chk("rst-held a0", dbg_data, 32'h0);
        clear_prog();
        prog[0] = enc_u(LUI, 12, 'h110);
        prog[1] = enc_i(LD, 10, 3'd2, 12, -4);          // RAM word written before reset
        start_prog();
        step();
        step();
        chk("ram kept a0", dbg_data, 32'h0000ABCD);

        // ---------------- Control flow, x0, NOP opcodes ----------------
        clear_prog();
        prog[0]  = enc_i(OPI, 11, 3'd0, 0, 3);          // x11 = 3
        prog[1]  = enc_i(OPI, 10, 3'd0, 10, 1);         // addi a0,a0,1
        prog[2]  = enc_b(3'd4, 10, 11, -4);             // blt a0,x11,-4
        prog[3]  = enc_j(0, 'h34);                      // j 0x40
        prog[16] = enc_j(1, 8);                         // 0x40 jal x1,+8
        prog[17] = enc_j(0, 'hC);                       // 0x44 j 0x50
        prog[18] = enc_i(JALR, 0, 3'd0, 1, 1);          // 0x48 jalr x0,x1,1
        prog[20] = enc_i(JALR, 1, 3'd0, 1, 'h10);       // 0x50 jalr x1,x1,16
        prog[21] = enc_i(OPI, 10, 3'd0, 1, 0);          // 0x54 mv a0,x1
        prog[22] = enc_b(3'd1, 11, 11, 8);              // 0x58 bne x11,x11 (not taken)
        prog[23] = enc_b(3'd7, 10, 11, 8);              // 0x5C bgeu a0,x11 (taken)
        prog[25] = enc_b(3'd5, 11, 10, 8);              // 0x64 bge x11,a0 (not taken)
        prog[26] = enc_i(OPI, 0, 3'd0, 0, 7);           // 0x68 addi x0,x0,7
        prog[27] = 32'h0000000B;                        // 0x6C undefined opcode
        prog[28] = enc_i(OPI, 10, 3'd0, 0, 0);          // 0x70 mv a0,x0
        prog[29] = 32'h00000073;                        // 0x74 ecall
        exp_d_pc = '{32'h04, 32'h08, 32'h04, 32'h08, 32'h04, 32'h08, 32'h0C, 32'h40, 32'h48, 32'h44,
                     32'h50, 32'h54, 32'h58, 32'h5C, 32'h64, 32'h68, 32'h6C, 32'h70, 32'h74, 32'h78};
        exp_d_a0 = '{32'h0, 32'h1, 32'h1, 32'h2, 32'h2, 32'h3, 32'h3, 32'h3, 32'h3, 32'h3,
                     32'h3, 32'h3, 32'h54, 32'h54, 32'h54, 32'h54, 32'h54, 32'h54, 32'h0, 32'h0};
        start_prog();
        for (int n = 1; n <= 20; n++) begin
            step();
            chk($sformatf("ctl pc n=%0d", n), dbg_pc, exp_d_pc[n]);
            chk($sformatf("ctl a0 n=%0d", n), dbg_data, exp_d_a0[n]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
